// File: rtl/sb_master.sv
// sb_master: single-outstanding bus master bridging a simple core request port onto a
// split read (AR/R) and write (W/B) handshake bus, with a per-phase timeout.
//
// Parameters:
//   TIMEOUT_CYC  cycles allowed per bus phase before abort (0 disables the timeout)
// Ports:
//   sb_clk, sb_rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready, req_we,
//   req_addr, req_wdata, req_wstrb        core request
//   rsp_valid, rsp_rdata, rsp_err         one-cycle completion pulse with data/error
//   sb_arvalid/sb_arready, sb_araddr      read address phase
//   sb_rvalid/sb_rready, sb_rdata         read data phase
//   sb_wvalid/sb_wready, sb_waddr,
//   sb_wdata, sb_wstrb                    write phase
//   sb_bvalid/sb_bready, sb_bresp         write response phase (bresp 1 = error)
module sb_master #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        sb_clk,
    input  logic        sb_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        sb_arvalid,
    input  logic        sb_arready,
    output logic [31:0] sb_araddr,
    input  logic        sb_rvalid,
    output logic        sb_rready,
    input  logic [31:0] sb_rdata,
    output logic        sb_wvalid,
    input  logic        sb_wready,
    output logic [31:0] sb_waddr,
    output logic [31:0] sb_wdata,
    output logic [3:0]  sb_wstrb,
    input  logic        sb_bvalid,
    output logic        sb_bready,
    input  logic        sb_bresp
);

    typedef enum logic [2:0] {StIdle, StAr, StR, StW, StB, StRsp} state_e;

    localparam bit          TimeoutEn = (TIMEOUT_CYC != 0);
    localparam logic [15:0] CntLast   = (TIMEOUT_CYC == 0) ? 16'd0 : 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rready_q, rready_d;
    logic        bready_q, bready_d;
    logic        expired;
    logic        in_phase;

    // Last permitted cycle of the current phase; a handshake in this cycle still wins.
    assign expired  = TimeoutEn && (cnt_q == CntLast);
    assign in_phase = (state_q == StAr) || (state_q == StR) ||
                      (state_q == StW)  || (state_q == StB);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    state_d = req_we ? StW : StAr;
                end
            end
            StAr: begin
                if (sb_arready) begin
                    state_d = StR;
                end else if (expired) begin
                    state_d = StRsp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            StR: begin
                if (sb_rvalid) begin
                    state_d = StRsp;
                    rdata_d = sb_rdata;
                    err_d   = 1'b0;
                end else if (expired) begin
                    state_d = StRsp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            StW: begin
                if (sb_wready) begin
                    state_d = StB;
                end else if (expired) begin
                    state_d = StRsp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            StB: begin
                if (sb_bvalid) begin
                    state_d = StRsp;
                    rdata_d = '0;
                    err_d   = sb_bresp;
                end else if (expired) begin
                    state_d = StRsp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            StRsp:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Counter restarts on every phase entry and only runs while a phase is held.
        if (in_phase && (state_d == state_q)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = '0;
        end

        // Registered from next state so the drain readies stay low while reset is held.
        rready_d = (state_d == StR) || (state_d == StIdle);
        bready_d = (state_d == StB) || (state_d == StIdle);
    end

    always_ff @(posedge sb_clk or negedge sb_rst_n) begin
        if (!sb_rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rready_q <= 1'b0;
            bready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rready_q <= rready_d;
            bready_q <= bready_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign rsp_valid  = (state_q == StRsp);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign sb_arvalid = (state_q == StAr);
    assign sb_araddr  = addr_q;
    assign sb_rready  = rready_q;
    assign sb_wvalid  = (state_q == StW);
    assign sb_waddr   = addr_q;
    assign sb_wdata   = wdata_q;
    assign sb_wstrb   = wstrb_q;
    assign sb_bready  = bready_q;

endmodule

// File: tb/tb_sb_master.sv
// tb_sb_master: self-checking bench for sb_master (TIMEOUT_CYC = 4). Directed vector table
// plus randomized transactions, each compared against a transaction-level timing model.
module tb_sb_master;

    localparam int TO = 4;

    logic        sb_clk = 1'b0;
    logic        sb_rst_n = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sb_arvalid, sb_arready = 1'b0;
    logic [31:0] sb_araddr;
    logic        sb_rvalid = 1'b0, sb_rready;
    logic [31:0] sb_rdata = '0;
    logic        sb_wvalid, sb_wready = 1'b0;
    logic [31:0] sb_waddr, sb_wdata;
    logic [3:0]  sb_wstrb;
    logic        sb_bvalid = 1'b0, sb_bready, sb_bresp = 1'b0;

    int checks = 0;
    int errors = 0;
    logic hold_bvalid = 1'b0;

    always #5 sb_clk = ~sb_clk;

    sb_master #(.TIMEOUT_CYC(TO)) dut (
        .sb_clk    (sb_clk),
        .sb_rst_n  (sb_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .sb_arvalid(sb_arvalid),
        .sb_arready(sb_arready),
        .sb_araddr (sb_araddr),
        .sb_rvalid (sb_rvalid),
        .sb_rready (sb_rready),
        .sb_rdata  (sb_rdata),
        .sb_wvalid (sb_wvalid),
        .sb_wready (sb_wready),
        .sb_waddr  (sb_waddr),
        .sb_wdata  (sb_wdata),
        .sb_wstrb  (sb_wstrb),
        .sb_bvalid (sb_bvalid),
        .sb_bready (sb_bready),
        .sb_bresp  (sb_bresp)
    );

    // d1/d2: index of the phase cycle (0 = first) in which the slave handshakes.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          d1;
        int          d2;
        logic [31:0] rdata;
        logic        bresp;
        logic        hold_b;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_p1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation: each phase lasts until its handshake or TO cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   p2;
        r = v;
        r.exp_p1 = (v.d1 < TO) ? v.d1 + 1 : TO;
        if (v.d1 >= TO) begin
            r.exp_err   = 1'b1;
            r.exp_rdata = '0;
            r.exp_lat   = r.exp_p1 + 1;
        end else begin
            p2 = (v.d2 < TO) ? v.d2 + 1 : TO;
            r.exp_lat = r.exp_p1 + p2 + 1;
            if (v.d2 >= TO) begin
                r.exp_err   = 1'b1;
                r.exp_rdata = '0;
            end else if (v.we) begin
                r.exp_err   = v.bresp;
                r.exp_rdata = '0;
            end else begin
                r.exp_err   = 1'b0;
                r.exp_rdata = v.rdata;
            end
        end
        return r;
    endfunction

    task automatic slave_idle();
        sb_arready = 1'b0;
        sb_wready  = 1'b0;
        sb_rvalid  = 1'b0;
        sb_rdata   = $urandom;
        sb_bvalid  = hold_bvalid;
        sb_bresp   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valids", {28'd0, sb_arvalid, sb_wvalid, rsp_valid, rsp_err}, 32'd0);
        check("rst_readies", {30'd0, sb_rready, sb_bready}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_araddr", sb_araddr, 32'd0);
        check("rst_waddr", sb_waddr, 32'd0);
        check("rst_wdata", sb_wdata, 32'd0);
        check("rst_wstrb", {28'd0, sb_wstrb}, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the rsp_valid cycle.
    task automatic run_txn(input vec_t t);
        int   cyc, p1c, p2c;
        logic got, fields_ok;
        cyc = 0; p1c = 0; p2c = 0; got = 1'b0; fields_ok = 1'b1;
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = t.we;
        req_addr  = t.addr;
        req_wdata = t.wdata;
        req_wstrb = t.wstrb;
        slave_idle();
        @(posedge sb_clk);
        while (!got && cyc < 40) begin
            @(negedge sb_clk);
            cyc++;
            req_valid = 1'b0;
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_wstrb = 4'($urandom);
            slave_idle();
            if (sb_arvalid && sb_wvalid) fields_ok = 1'b0;
            if (sb_arvalid) begin
                p1c++;
                if (t.we || sb_araddr !== t.addr) fields_ok = 1'b0;
                sb_arready = (p1c - 1 == t.d1);
            end else if (sb_wvalid) begin
                p1c++;
                if (!t.we || sb_waddr !== t.addr || sb_wdata !== t.wdata ||
                    sb_wstrb !== t.wstrb) fields_ok = 1'b0;
                sb_wready = (p1c - 1 == t.d1);
            end else if (sb_rready && !req_ready) begin
                p2c++;
                if (p2c - 1 == t.d2) begin
                    sb_rvalid = 1'b1;
                    sb_rdata  = t.rdata;
                end
            end else if (sb_bready && !req_ready) begin
                p2c++;
                if (p2c - 1 == t.d2) begin
                    sb_bvalid = 1'b1;
                    sb_bresp  = t.bresp;
                end
            end else if (rsp_valid) begin
                got = 1'b1;
            end
        end
        check("rsp_seen", {31'd0, got}, 32'd1);
        check("rsp_latency", cyc, t.exp_lat);
        check("rsp_rdata", rsp_rdata, t.exp_rdata);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, t.exp_err});
        check("phase1_cycles", p1c, t.exp_p1);
        check("bus_fields", {31'd0, fields_ok}, 32'd1);
        @(negedge sb_clk);
        slave_idle();
        check("rsp_one_cycle", {30'd0, rsp_valid, req_ready}, 32'd1);
        check("rsp_hold", {rsp_rdata[30:0], rsp_err}, {t.exp_rdata[30:0], t.exp_err});
    endtask

    vec_t tbl[10];
    vec_t v;

    initial begin
        //        we    addr          wdata         strb  d1   d2  rdata         bresp hold
        //        err   exp_rdata     lat p1
        tbl[0] = '{1'b0, 32'h0000_1000, 32'h0,        4'h0, 0,   0, 32'h0000_A5A5, 1'b0, 1'b0,
                   1'b0, 32'h0000_A5A5, 3, 1};
        tbl[1] = '{1'b1, 32'h0000_0000, 32'h0000_1234, 4'hF, 0,   0, 32'h0,        1'b0, 1'b0,
                   1'b0, 32'h0,        3, 1};
        tbl[2] = '{1'b1, 32'h0000_0040, 32'hFFFF_0000, 4'h3, 0,   0, 32'h0,        1'b1, 1'b1,
                   1'b1, 32'h0,        3, 1};
        tbl[3] = '{1'b0, 32'h0000_0044, 32'h0,        4'h0, 0,   0, 32'h600D_F00D, 1'b0, 1'b1,
                   1'b0, 32'h600D_F00D, 3, 1};
        tbl[4] = '{1'b0, 32'h8000_0000, 32'h0,        4'h0, 100, 0, 32'h0000_0BAD, 1'b0, 1'b0,
                   1'b1, 32'h0,        5, 4};
        tbl[5] = '{1'b1, 32'h0000_0100, 32'hCAFE_0001, 4'h5, 3,   0, 32'h0,        1'b0, 1'b0,
                   1'b0, 32'h0,        6, 4};
        tbl[6] = '{1'b0, 32'h0000_0200, 32'h0,        4'h0, 1,   3, 32'h1357_2468, 1'b0, 1'b0,
                   1'b0, 32'h1357_2468, 7, 2};
        tbl[7] = '{1'b1, 32'h0000_0300, 32'h0000_00FF, 4'h1, 0,   4, 32'h0,        1'b0, 1'b0,
                   1'b1, 32'h0,        6, 1};
        tbl[8] = '{1'b0, 32'h0000_0400, 32'h0,        4'h0, 0,   5, 32'h7777_7777, 1'b0, 1'b0,
                   1'b1, 32'h0,        6, 1};
        tbl[9] = '{1'b0, 32'h0000_0500, 32'h0,        4'h0, 2,   1, 32'hDEAD_BEEF, 1'b0, 1'b0,
                   1'b0, 32'hDEAD_BEEF, 6, 3};

        #2 sb_rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge sb_clk);
        sb_rst_n = 1'b1;
        @(negedge sb_clk);
        check("idle_drain_readies", {30'd0, sb_rready, sb_bready}, 32'd3);

        // Entries 2 and 3 hold bvalid high from the write through the back-to-back read.
        for (int i = 0; i < 10; i++) begin
            hold_bvalid = tbl[i].hold_b;
            run_txn(tbl[i]);
        end
        hold_bvalid = 1'b0;
        slave_idle();

        // Reset while parked in R abandons the read with no response.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'hCAFE_0000;
        @(negedge sb_clk);
        req_valid  = 1'b0;
        sb_arready = 1'b1;
        @(negedge sb_clk);
        sb_arready = 1'b0;
        check("parked_in_r", {29'd0, sb_rready, req_ready, sb_arvalid}, 32'd4);
        sb_rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge sb_clk);
        sb_rvalid = 1'b1;
        sb_rdata  = 32'h5555_AAAA;
        @(negedge sb_clk);
        check("no_rsp_in_reset", {30'd0, rsp_valid, req_ready}, 32'd1);
        sb_rvalid = 1'b0;
        sb_rst_n  = 1'b1;
        @(negedge sb_clk);
        check("after_release", {29'd0, rsp_valid, req_ready, sb_rready}, 32'd3);
        check("after_release_rdata", rsp_rdata, 32'd0);
        v = tbl[0];
        v.addr  = 32'h0000_2000;
        v.rdata = 32'h0BAD_CAFE;
        run_txn(model(v));

        for (int i = 0; i < 40; i++) begin
            v.we     = 1'($urandom_range(0, 1));
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.wstrb  = 4'($urandom);
            v.d1     = $urandom_range(0, 5);
            v.d2     = $urandom_range(0, 5);
            v.rdata  = $urandom;
            v.bresp  = 1'($urandom_range(0, 1));
            v.hold_b = 1'b0;
            run_txn(model(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_master.md
SB_MASTER -- requirements
Module: sb_master

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, cycles allowed per bus phase before abort (0 = no timeout, range 0..65535).
REQ-002 One clock, sb_clk; reset sb_rst_n is asynchronous, active-low.
REQ-003 sb_clk  input  1  clock, all state on rising edge.
REQ-004 sb_rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  core request valid.
REQ-006 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address, passed unmodified.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_wstrb  input  4  write byte strobes.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  error flag, valid with rsp_valid.
REQ-014 sb_arvalid / sb_arready  output / input  1 / 1  read address handshake.
REQ-015 sb_araddr  output  32  read address.
REQ-016 sb_rvalid / sb_rready  input / output  1 / 1  read data handshake.
REQ-017 sb_rdata  input  32  read data.
REQ-018 sb_wvalid / sb_wready  output / input  1 / 1  write handshake.
REQ-019 sb_waddr / sb_wdata  output  32 / 32  write address and data.
REQ-020 sb_wstrb  output  4  write strobes.
REQ-021 sb_bvalid / sb_bready / sb_bresp  input / output / input  1 / 1 / 1  write response, bresp 1 = error.

Function
REQ-022 FSM states: IDLE, AR, R, W, B, RSP; all sb_* and rsp_* outputs are registered or decoded from state only, with no input-to-output combinational path.
REQ-023 req_ready = 1 in IDLE only. On accept, latch addr/wdata/wstrb; go to W if req_we, else AR.
REQ-024 AR: sb_arvalid=1, sb_araddr = latched addr held stable; on sb_arready=1, go to R.
REQ-025 R: sb_rready=1; on sb_rvalid=1, capture sb_rdata into rsp_rdata, rsp_err=0, go to RSP.
REQ-026 W: sb_wvalid=1 with sb_waddr/sb_wdata/sb_wstrb held stable; on sb_wready=1, go to B.
REQ-027 B: sb_bready=1; on sb_bvalid=1, rsp_err=sb_bresp, rsp_rdata=0, go to RSP.
REQ-028 RSP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata/rsp_err hold until the next RSP.
REQ-029 sb_rready and sb_bready are also 1 in IDLE, so stale responses are drained and discarded; sb_rvalid/sb_bvalid are ignored in AR, W, RSP.
REQ-030 Latency with always-ready slave, 1-cycle registered response: accept edge cycle T; AR/W in T+1; R/B in T+2; rsp_valid in T+3; req_ready again in T+4.
REQ-031 16-bit timeout counter cleared on entry to AR, R, W, B and incremented each cycle in those states. When count == TIMEOUT_CYC-1 without the exiting handshake, go to RSP with rsp_err=1, rsp_rdata=0; the bus valid drops the next cycle.
REQ-032 A handshake in the same cycle as timeout expiry takes priority over the timeout (normal completion).
REQ-033 sb_arvalid and sb_wvalid are never high simultaneously, and never high outside AR/W.

Reset
REQ-034 While sb_rst_n=0: state IDLE, req_ready=1, and all other outputs 0 (including rsp_rdata, rsp_err, address/data/strobe registers and counter); reset mid-transaction abandons it with no rsp_valid.

Verification
REQ-035 Read, slave arready=1 and rvalid one cycle later with rdata=0x0000_A5A5 -> rsp_valid in T+3, rsp_rdata=0x0000A5A5, rsp_err=0.
REQ-036 Write addr=0x0, wdata=0x1234, wstrb=0xF, bresp=0 -> sb_wvalid for 1 cycle carrying those values; rsp_valid in T+3, rsp_err=0, rsp_rdata=0.
REQ-037 Write with bresp=1 -> rsp_err=1. Back-to-back read issued in T+4 -> completes normally, with the stale bvalid drained in IDLE.
REQ-038 TIMEOUT_CYC=4, sb_arready stuck 0 -> sb_arvalid high for exactly 4 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0.
REQ-039 TIMEOUT_CYC=4, sb_wready rises on the 4th W cycle -> normal completion, rsp_err=sb_bresp.
REQ-040 sb_rst_n asserted while in R -> outputs 0 and req_ready=1 immediately; after release, a new read completes correctly.
